// File: rtl/ni_input_unit_mc_pkg.sv
// Flit info codes, broadcast phase encoding and flit decode helper
// shared by the PE network-interface input unit.
package ni_input_unit_mc_pkg;

  localparam int ROUTER_INFO_CONFIG    = 1;
  localparam int ROUTER_INFO_CALC      = 2;
  localparam int ROUTER_INFO_BROADCAST = 3;
  localparam int ROUTER_INFO_FIN_BCAST = 4;
  localparam int ROUTER_INFO_FIN_COMP  = 5;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_BCAST = 2'd1,
    PH_DRAIN = 2'd2,
    PH_DONE  = 2'd3
  } phase_t;

  typedef struct packed {
    logic cfg;
    logic calc;
    logic bcast;
    logic fin_bcast;
    logic fin_comp;
  } flit_dec_t;

  function automatic flit_dec_t decode_info(input int info);
    flit_dec_t d;
    d = '0;
    unique case (info)
      ROUTER_INFO_CONFIG:    d.cfg       = 1'b1;
      ROUTER_INFO_CALC:      d.calc      = 1'b1;
      ROUTER_INFO_BROADCAST: d.bcast     = 1'b1;
      ROUTER_INFO_FIN_BCAST: d.fin_bcast = 1'b1;
      ROUTER_INFO_FIN_COMP:  d.fin_comp  = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ni_act_fifo.sv
// Synchronous activation FIFO; push/pop arrive already qualified
// by the caller (no push when full without pop, no pop when empty).
module ni_act_fifo #(
  parameter int W = 22,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // Head reads as zero when empty so stale entries never leak out.
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ni_input_unit_mc.sv
// PE network-interface input unit: flit decode, activation queue,
// accumulated upstream credit return and broadcast phase tracking.
module ni_input_unit_mc
  import ni_input_unit_mc_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int INFO_W    = 4,
  parameter int ACT_NO_W  = 6,
  parameter int PE_ADDR_W = 6,
  parameter int QDEPTH    = 8,
  parameter int CRED_W    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_data_valid,
  input  logic [INFO_W+ADDR_W+DATA_W-1:0]  in_data,
  input  logic [ACT_NO_W-1:0]              out_act_no,
  output logic                             pe_status_we,
  output logic [3:0]                       pe_status_addr,
  output logic [DATA_W-1:0]                pe_status_data,
  output logic                             in_act_write_en,
  output logic [ACT_NO_W-1:0]              in_act_write_addr,
  output logic [DATA_W-1:0]                in_act_write_data,
  output logic                             pe_start_calc,
  output logic                             broadcast_done,
  output logic                             comp_done,
  input  logic                             act_pop,
  output logic                             act_valid,
  output logic [PE_ADDR_W+DATA_W-1:0]      act_data,
  output logic [$clog2(QDEPTH):0]          act_count,
  output logic                             upstream_credit,
  output logic [1:0]                       phase,
  output logic                             err_overflow
);

  localparam int AW = $clog2(QDEPTH);

  logic [DATA_W-1:0] f_data;
  logic [ADDR_W-1:0] f_addr;
  logic [INFO_W-1:0] f_info;
  flit_dec_t         dec;
  logic              unused_addr;

  assign f_data = in_data[DATA_W-1:0];
  assign f_addr = in_data[DATA_W +: ADDR_W];
  assign f_info = in_data[DATA_W+ADDR_W +: INFO_W];
  assign dec = in_data_valid ? decode_info(int'(f_info)) : '0;
  assign unused_addr = ^f_addr;

  logic status_hit;
  logic act_hit;

  assign status_hit = dec.cfg & ~f_addr[7];
  assign act_hit    = dec.cfg &  f_addr[7];

  assign pe_status_we      = status_hit;
  assign pe_status_addr    = status_hit ? f_addr[3:0] : '0;
  assign pe_status_data    = status_hit ? f_data : '0;
  assign in_act_write_en   = act_hit;
  assign in_act_write_addr = act_hit ? f_addr[ACT_NO_W:1] : '0;
  assign in_act_write_data = act_hit ? f_data : '0;
  assign pe_start_calc     = dec.calc;
  assign comp_done         = dec.fin_comp;

  phase_t        state;
  logic          q_full;
  logic          q_empty;
  logic [AW:0]   q_count;
  logic [AW:0]   q_next;
  logic          push_req;
  logic          push_ok;
  logic          pop_ok;
  logic          consumed;
  logic          q_drained;

  assign push_req = dec.bcast && (out_act_no != '0) &&
                    (state == PH_BCAST || state == PH_DRAIN);
  assign pop_ok   = act_pop && !q_empty;
  // A full queue still accepts a push when the head leaves this cycle.
  assign push_ok  = push_req && (!q_full || pop_ok);
  assign consumed = dec.cfg | dec.calc | dec.fin_bcast |
                    dec.fin_comp | (dec.bcast & ~push_ok);
  assign q_next   = q_count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  assign q_drained = (q_next == '0);

  ni_act_fifo #(
    .W     (PE_ADDR_W + DATA_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push_ok),
    .pop   (pop_ok),
    .wdata ({f_addr[PE_ADDR_W-1:0], f_data}),
    .rdata (act_data),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign act_valid = !q_empty;
  assign act_count = q_count;
  assign phase     = state;

  logic [CRED_W-1:0] cnt;
  logic [CRED_W:0]   avail;
  logic [CRED_W:0]   avail_m1;

  assign avail = {1'b0, cnt} + (CRED_W+1)'(consumed) +
                 (CRED_W+1)'(pop_ok);
  assign avail_m1 = avail - (CRED_W+1)'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt             <= '0;
      upstream_credit <= 1'b0;
    end else if (avail != '0) begin
      assert (!avail_m1[CRED_W]);
      upstream_credit <= 1'b1;
      cnt <= avail_m1[CRED_W] ? '1 : avail_m1[CRED_W-1:0];
    end else begin
      upstream_credit <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_overflow <= 1'b0;
    end else if (push_req && q_full && !pop_ok) begin
      err_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= PH_IDLE;
      broadcast_done <= 1'b0;
    end else begin
      broadcast_done <= 1'b0;
      unique case (state)
        PH_IDLE: if (dec.calc) state <= PH_BCAST;
        PH_BCAST: begin
          if (dec.fin_bcast) begin
            if (q_drained) begin
              state          <= PH_DONE;
              broadcast_done <= 1'b1;
            end else begin
              state <= PH_DRAIN;
            end
          end
        end
        PH_DRAIN: begin
          if (q_drained) begin
            state          <= PH_DONE;
            broadcast_done <= 1'b1;
          end
        end
        PH_DONE: if (dec.fin_comp) state <= PH_IDLE;
        default: state <= PH_IDLE;
      endcase
    end
  end

endmodule
